// File: rtl/axil_pkg.sv
// Shared types for the AXI4-Lite register front end: response codes,
// channel FSM states and the address decoder used by both channels.
package axil_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_EXEC,
        W_RESP
    } wstate_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_RESP
    } rstate_t;

    typedef struct packed {
        logic        in_range;
        logic [31:0] index;
    } addr_dec_t;

    // Addresses are widened to 64 bits so any ADDR_WIDTH up to 64 decodes the same way.
    function automatic addr_dec_t addr_decode(input logic [63:0] addr, input int unsigned num_regs);
        addr_dec_t dec;
        dec.in_range = (addr < ({32'd0, num_regs} << 2));
        dec.index    = addr[33:2];
        return dec;
    endfunction

endpackage

// File: rtl/axil_slave_if.sv
// AXI4-Lite slave that turns bus transactions into single-cycle register bank
// accesses; independent write and read channel FSMs, all outputs registered.
module axil_slave_if
    import axil_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 16,
    parameter int unsigned RO_INDEX   = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,

    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]              s_axi_awprot,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,

    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,

    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,

    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]              s_axi_arprot,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,

    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,

    output logic                    write_en,
    output logic [31:0]             write_addr,
    output logic [DATA_WIDTH-1:0]   write_data,

    output logic [31:0]             read_addr,
    input  logic [DATA_WIDTH-1:0]   read_data
);

    // ---------------- write channel ----------------
    wstate_t                   wstate_q, wstate_d;
    logic                      aw_held_q, aw_held_d;
    logic                      w_held_q, w_held_d;
    logic                      awready_q, awready_d;
    logic                      wready_q, wready_d;
    logic                      bvalid_q, bvalid_d;
    resp_t                     bresp_q, bresp_d;
    logic                      write_en_q, write_en_d;
    logic [ADDR_WIDTH-1:0]     awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;

    logic                      aw_fire, w_fire;
    logic [ADDR_WIDTH-1:0]     aw_addr_sel;
    logic [DATA_WIDTH/8-1:0]   w_strb_sel;
    addr_dec_t                 wr_dec;

    assign aw_fire     = (wstate_q == W_IDLE) && s_axi_awvalid && awready_q;
    assign w_fire      = (wstate_q == W_IDLE) && s_axi_wvalid && wready_q;
    // Decode on the beat being captured this cycle so write_en lands one cycle after the later handshake.
    assign aw_addr_sel = aw_fire ? s_axi_awaddr : awaddr_q;
    assign w_strb_sel  = w_fire ? s_axi_wstrb : wstrb_q;
    assign wr_dec      = addr_decode(64'(aw_addr_sel), NUM_REGS);

    always_comb begin
        wstate_d   = wstate_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        write_en_d = 1'b0;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;

        case (wstate_q)
            W_IDLE: begin
                if (aw_fire) begin
                    awaddr_d  = s_axi_awaddr;
                    aw_held_d = 1'b1;
                end
                if (w_fire) begin
                    wdata_d  = s_axi_wdata;
                    wstrb_d  = s_axi_wstrb;
                    w_held_d = 1'b1;
                end
                awready_d = !aw_held_d;
                wready_d  = !w_held_d;

                if (aw_held_d && w_held_d) begin
                    wstate_d  = W_EXEC;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    if (!wr_dec.in_range) begin
                        bresp_d = RESP_DECERR;
                    end else if (w_strb_sel != '1) begin
                        bresp_d = RESP_SLVERR;
                    end else if (wr_dec.index == RO_INDEX) begin
                        bresp_d = RESP_SLVERR;
                    end else begin
                        bresp_d    = RESP_OKAY;
                        write_en_d = 1'b1;
                    end
                end
            end
            W_EXEC: begin
                wstate_d = W_RESP;
                bvalid_d = 1'b1;
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    wstate_d  = W_IDLE;
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wstate_q   <= W_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            write_en_q <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
        end else begin
            wstate_q   <= wstate_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            write_en_q <= write_en_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
        end
    end

    // ---------------- read channel ----------------
    rstate_t                 rstate_q, rstate_d;
    logic                    arready_q, arready_d;
    logic                    rvalid_q, rvalid_d;
    resp_t                   rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0]   read_addr_q, read_addr_d;
    addr_dec_t               rd_dec;

    assign rd_dec = addr_decode(64'(read_addr_q), NUM_REGS);

    always_comb begin
        rstate_d    = rstate_q;
        arready_d   = arready_q;
        rvalid_d    = rvalid_q;
        rresp_d     = rresp_q;
        rdata_d     = rdata_q;
        read_addr_d = read_addr_q;

        case (rstate_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (s_axi_arvalid && arready_q) begin
                    read_addr_d = s_axi_araddr;
                    arready_d   = 1'b0;
                    rstate_d    = R_FETCH;
                end
            end
            R_FETCH: begin
                // The bank port is combinational; sampling here sees the pre-write value on a same-cycle write.
                if (rd_dec.in_range) begin
                    rdata_d = read_data;
                    rresp_d = RESP_OKAY;
                end else begin
                    rdata_d = '0;
                    rresp_d = RESP_DECERR;
                end
                rvalid_d = 1'b1;
                rstate_d = R_RESP;
            end
            R_RESP: begin
                if (s_axi_rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    rstate_d  = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rstate_q    <= R_IDLE;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rresp_q     <= RESP_OKAY;
            rdata_q     <= '0;
            read_addr_q <= '0;
        end else begin
            rstate_q    <= rstate_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
            rresp_q     <= rresp_d;
            rdata_q     <= rdata_d;
            read_addr_q <= read_addr_d;
        end
    end

    // ---------------- outputs ----------------
    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;
    assign write_en      = write_en_q;
    assign write_addr    = 32'(awaddr_q);
    assign write_data    = wdata_q;
    assign read_addr     = 32'(read_addr_q);

    logic unused_ok;
    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, rd_dec.index};

endmodule

// File: tb/tb_axil_slave_if.sv
// Directed bench for axil_slave_if with a small combinational-read register bank model.
module tb_axil_slave_if;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [31:0] araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        write_en;
    logic [31:0] write_addr;
    logic [31:0] write_data;
    logic [31:0] read_addr;
    logic [31:0] read_data;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    axil_slave_if dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .s_axi_awaddr  (awaddr),
        .s_axi_awprot  (awprot),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arprot  (arprot),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .write_en      (write_en),
        .write_addr    (write_addr),
        .write_data    (write_data),
        .read_addr     (read_addr),
        .read_data     (read_data)
    );

    // Register bank model: reg2 and the read-only reg3 carry known preset values.
    logic [31:0] bank [16];
    logic        bank_clear = 1'b1;
    int          we_count = 0;

    always @(posedge clk) begin
        if (bank_clear) begin
            for (int i = 0; i < 16; i++) bank[i] <= 32'h0;
            bank[2] <= 32'h0000_0808;
            bank[3] <= 32'hA5A5_0003;
        end else if (write_en) begin
            bank[write_addr[5:2]] <= write_data;
            we_count <= we_count + 1;
        end
    end

    assign read_data = bank[read_addr[5:2]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int w_delay,
                            input logic [1:0] exp_resp, input int exp_we);
        int we_start;
        bit aw_done, w_done, aw_f, w_f;
        aw_done  = 0;
        w_done   = 0;
        we_start = we_count;
        @(negedge clk);
        awaddr  = addr;
        awvalid = 1'b1;
        for (int c = 0; c < 40 && !(aw_done && w_done); c++) begin
            if (c == w_delay) begin
                wdata  = data;
                wstrb  = strb;
                wvalid = 1'b1;
            end
            aw_f = awvalid && awready;
            w_f  = wvalid && wready;
            @(negedge clk);
            if (aw_f) begin awvalid = 1'b0; aw_done = 1; end
            if (w_f)  begin wvalid  = 1'b0; w_done  = 1; end
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check({tag, "_handshake"}, 32'(aw_done && w_done), 32'd1);
        check({tag, "_write_en"}, 32'(write_en), 32'(exp_we != 0));
        if (exp_we != 0) begin
            check({tag, "_write_addr"}, write_addr, addr);
            check({tag, "_write_data"}, write_data, data);
        end
        bready = 1'b1;
        @(negedge clk);
        check({tag, "_bvalid"}, 32'(bvalid), 32'd1);
        check({tag, "_bresp"}, 32'(bresp), 32'(exp_resp));
        check({tag, "_awready_in_resp"}, 32'(awready), 32'd0);
        @(negedge clk);
        bready = 1'b0;
        check({tag, "_bvalid_done"}, 32'(bvalid), 32'd0);
        check({tag, "_we_pulses"}, 32'(we_count - we_start), 32'(exp_we));
        $display("write %s addr=0x%08h data=0x%08h strb=%h bresp=%0d", tag, addr, data, strb, exp_resp);
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr, input int hold,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp);
        bit fired, f;
        fired = 0;
        @(negedge clk);
        araddr  = addr;
        arvalid = 1'b1;
        for (int c = 0; c < 20 && !fired; c++) begin
            f = arvalid && arready;
            @(negedge clk);
            if (f) begin arvalid = 1'b0; fired = 1; end
        end
        arvalid = 1'b0;
        check({tag, "_ar_handshake"}, 32'(fired), 32'd1);
        check({tag, "_read_addr"}, read_addr, addr);
        check({tag, "_rvalid_early"}, 32'(rvalid), 32'd0);
        @(negedge clk);
        check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
        check({tag, "_rdata"}, rdata, exp_data);
        check({tag, "_rresp"}, 32'(rresp), 32'(exp_resp));
        check({tag, "_arready_in_resp"}, 32'(arready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_rvalid"}, 32'(rvalid), 32'd1);
            check({tag, "_hold_rdata"}, rdata, exp_data);
            check({tag, "_hold_arready"}, 32'(arready), 32'd0);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check({tag, "_rvalid_done"}, 32'(rvalid), 32'd0);
        $display("read  %s addr=0x%08h data=0x%08h rresp=%0d", tag, addr, exp_data, exp_resp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_awready"},    32'(awready), 32'd0);
        check({tag, "_wready"},     32'(wready), 32'd0);
        check({tag, "_arready"},    32'(arready), 32'd0);
        check({tag, "_bvalid"},     32'(bvalid), 32'd0);
        check({tag, "_rvalid"},     32'(rvalid), 32'd0);
        check({tag, "_write_en"},   32'(write_en), 32'd0);
        check({tag, "_bresp"},      32'(bresp), 32'd0);
        check({tag, "_rresp"},      32'(rresp), 32'd0);
        check({tag, "_rdata"},      rdata, 32'd0);
        check({tag, "_write_addr"}, write_addr, 32'd0);
        check({tag, "_write_data"}, write_data, 32'd0);
        check({tag, "_read_addr"},  read_addr, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        repeat (3) @(negedge clk);
        bank_clear = 1'b0;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset_aw", 32'(awready), 32'd1);
        check("ready_after_reset_w",  32'(wready), 32'd1);
        check("ready_after_reset_ar", 32'(arready), 32'd1);

        do_write("wr00", 32'h00, 32'h0000_0012, 4'hF, 2, OKAY, 1);
        do_read("rd00", 32'h00, 0, 32'h0000_0012, OKAY);

        do_write("wr0c_ro", 32'h0C, 32'hDEAD_BEEF, 4'hF, 0, SLVERR, 0);
        do_read("rd0c", 32'h0C, 0, 32'hA5A5_0003, OKAY);

        do_write("wr40", 32'h40, 32'h1234_5678, 4'hF, 0, DECERR, 0);
        do_read("rd44", 32'h44, 0, 32'h0, DECERR);

        do_write("wr04_strb", 32'h04, 32'h0000_FFFF, 4'h3, 1, SLVERR, 0);
        do_read("rd04_hold", 32'h04, 5, 32'h0, OKAY);

        fork
            do_write("wr10", 32'h10, 32'h0000_1010, 4'hF, 0, OKAY, 1);
            do_read("rd08", 32'h08, 0, 32'h0000_0808, OKAY);
        join
        do_read("rd10", 32'h10, 0, 32'h0000_1010, OKAY);

        // Abort a write while its response is pending.
        @(negedge clk);
        awaddr = 32'h14; wdata = 32'h55; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (bvalid) seen = 1;
            else @(negedge clk);
        end
        check("abort_reach_resp", 32'(seen), 32'd1);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("abort_reset");
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("abort_no_bvalid", 32'(bvalid), 32'd0);
            check("abort_no_write_en", 32'(write_en), 32'd0);
        end
        check("abort_awready", 32'(awready), 32'd1);
        $display("reset during write response done");

        do_write("wr18", 32'h18, 32'h0000_0077, 4'hF, 0, OKAY, 1);
        do_read("rd18", 32'h18, 0, 32'h0000_0077, OKAY);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axil_slave_if.md
# axil_slave_if

AXI4-Lite slave front end for the register bank: terminates the five AXI4-Lite channels and converts each transaction into the bank's simple port pair (`write_en`/`write_addr`/`write_data` and `read_addr`/`read_data`). It sits directly upstream of the register bank and is the only path by which the bus master reaches the ALU and memory registers. It also generates response codes. Writes to the read-only result register, partial-strobe writes and out-of-range accesses are rejected without disturbing the bank.

## Interface
- `ADDR_WIDTH`, 32: AXI address width.
- `DATA_WIDTH`, 32: AXI data width; only 32 is supported.
- `NUM_REGS`, 16: bank depth; the decoded window is `NUM_REGS*4` bytes (0x00–0x3F).
- `RO_INDEX`, 3: word index of the read-only ALU result register.

Ports:
- `clk` in 1: single clock.
- `reset_n` in 1: reset, synchronous and active-low.
- `s_axi_awaddr` in ADDR_WIDTH, `s_axi_awprot` in 3 (ignored), `s_axi_awvalid` in 1, `s_axi_awready` out 1: write address channel.
- `s_axi_wdata` in 32, `s_axi_wstrb` in 4, `s_axi_wvalid` in 1, `s_axi_wready` out 1: write data channel.
- `s_axi_bresp` out 2, `s_axi_bvalid` out 1, `s_axi_bready` in 1: write response channel.
- `s_axi_araddr` in ADDR_WIDTH, `s_axi_arprot` in 3 (ignored), `s_axi_arvalid` in 1, `s_axi_arready` out 1: read address channel.
- `s_axi_rdata` out 32, `s_axi_rresp` out 2, `s_axi_rvalid` out 1, `s_axi_rready` in 1: read data channel.
- `write_en` out 1, `write_addr` out 32, `write_data` out 32: to bank write port.
- `read_addr` out 32, `read_data` in 32: to bank read port. The bank's read port is combinational.

## Operation
- Response codes: OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11.
- Write FSM states: W_IDLE, W_EXEC, W_RESP.
  - W_IDLE: `awready` is high until AW is captured; `wready` is high until W is captured. AW and W may arrive in either order or in the same cycle. Each captured beat is held in a local register.
  - When both beats are held, go to W_EXEC.
  - Decode in W_EXEC:
    - `awaddr >= NUM_REGS*4` → DECERR, no write.
    - Otherwise, `wstrb != 4'hF` → SLVERR, no write.
    - Otherwise, `awaddr[5:2] == RO_INDEX` → SLVERR, no write.
    - Otherwise → OKAY, and `write_en` is high for exactly this cycle with the latched `write_addr` and `write_data`.
  - W_EXEC always lasts one cycle, then go to W_RESP.
  - W_RESP: `bvalid` is high with `bresp`; `awready` and `wready` are low. On `bvalid && bready`, return to W_IDLE.
- Read FSM states: R_IDLE, R_FETCH, R_RESP.
  - R_IDLE: `arready` = 1; on handshake, latch `araddr` into `read_addr` and go to R_FETCH.
  - R_FETCH: register `rdata`. If `araddr >= NUM_REGS*4`, `rdata` = 0 and `rresp` = DECERR; otherwise `rdata` = `read_data` and `rresp` = OKAY. Go to R_RESP.
  - R_RESP: `rvalid` is high; `rdata`/`rresp` are stable until `rready`; `arready` is low. Then return to R_IDLE.
- `write_addr`, `write_data` and `read_addr` hold their last latched value between transactions.
- Read and write FSMs are independent and may run concurrently.
- If the bank write and the read sample land in the same cycle at the same address, the read returns the pre-write value.
- No ordering is enforced between read and write channels. Each channel handles one outstanding transaction.

## Timing
- Reset values: all `*ready`, `bvalid`, `rvalid` and `write_en` = 0; `bresp`, `rresp` = 2'b00; `rdata`, `write_addr`, `write_data`, `read_addr` = 0; both FSMs in IDLE.
- Ready signals are asserted in the first cycle after reset release.
- Write: the later of the AW/W handshakes occurs at edge N → `write_en` is high in cycle N+1 → `bvalid` is high from N+2. Minimum is 3 cycles from handshake to the next acceptance.
- Read: AR handshake at edge N → `read_addr` is valid in N+1 → `rvalid` is high from N+2.
- VALID is never deasserted before its handshake. All outputs are registered.
- Reset asserted mid-transaction aborts it. The latched beat is discarded, no `write_en` is issued, and no response is issued.

## Structure
- Package `axil_pkg` holds:
  - the `resp_t` encodings (OKAY/SLVERR/DECERR);
  - the `wstate_t`/`rstate_t` enums;
  - an `addr_decode` function returning in-range and word-index.
- No sub-module: both FSMs live in this module. The read and write FSMs are separate `always` blocks.

## Test plan
- AW then W two cycles later, addr 0x00, data 0x0000_0012, strb F → one `write_en` pulse with `write_addr` 0x00; `bresp` OKAY; bank reg0 reads back 0x12.
- AW and W in the same cycle, addr 0x0C → no `write_en`; `bresp` SLVERR.
- Write to 0x40 → DECERR with no `write_en`. Read of 0x44 → `rdata` 0, `rresp` DECERR.
- Write with `wstrb` = 4'h3 to 0x04 → SLVERR; reg1 is unchanged.
- Read 0x04 with `rready` held low for 5 cycles → `rvalid`/`rdata` stable throughout; `arready` stays 0 until the handshake.
- Concurrent write to 0x10 and read of 0x08. Then assert reset while in W_RESP → all outputs return to their reset values, no response is issued, and the next transaction completes normally.
